// File: rtl/sync_fifo_wr_arb.sv
// Round-robin write arbiter sharing one sync FIFO write port among NUM_REQ producers.
// Optional burst locking is enabled by defining FIFO_ARB_BURST_EN.
module sync_fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IW = $clog2(NUM_REQ);

    // Reject configurations the arbiter cannot serve.
    if ((NUM_REQ < 2) || (BURST_LEN < 1)) begin : g_bad_cfg
        $error("sync_fifo_wr_arb: NUM_REQ must be >= 2 and BURST_LEN >= 1");
    end

    logic [IW-1:0]         r_last_ptr;
    logic [IW-1:0]         w_rr_idx;
    logic                  w_rr_found;
    logic [IW-1:0]         w_pos;
    logic [IW-1:0]         w_gid;
    logic                  w_gv;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_data;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_pos      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = IW'((int'(r_last_ptr) + k) % NUM_REQ);
            if (!w_rr_found && req[w_pos]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_pos;
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(BURST_LEN) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] w_owner_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [CW-1:0] w_cnt_inc;

    // Grant selection: locked owner only, otherwise round-robin winner.
    always_comb begin
        w_gid = w_rr_idx;
        w_gv  = |req;
        if (r_state == S_LOCK) begin
            w_gid = r_owner;
            w_gv  = req[r_owner];
        end
    end

    // Burst FSM next state: lock on first beat, release on length or drop.
    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_cnt_nx   = r_cnt;
        w_cnt_inc  = r_cnt + CW'(1);
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && (BURST_LEN > 1)) begin
                    w_state_nx = S_LOCK;
                    w_owner_nx = w_gid;
                    w_cnt_nx   = CW'(1);
                end
            end
            S_LOCK: begin
                if (!fifo_full) begin
                    if (!req[r_owner]) begin
                        w_state_nx = S_IDLE;
                        w_cnt_nx   = '0;
                    end else if (w_cnt_inc == CW'(BURST_LEN)) begin
                        w_state_nx = S_IDLE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx   = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Burst FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_cnt   <= w_cnt_nx;
        end
    end
`else
    // Without burst locking the arbiter is always in round-robin mode.
    always_comb begin
        w_gid = w_rr_idx;
        w_gv  = |req;
    end
`endif

    assign w_accept = w_gv & ~fifo_full;

    // Ready, write data mux and grant outputs.
    always_comb begin
        req_ready = '0;
        w_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gv && (w_gid == IW'(i))) begin
                req_ready[i] = ~fifo_full;
                w_data       = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fifo_wr_en   = w_accept;
    assign fifo_wr_data = w_data;
    assign grant_valid  = w_gv;
    assign grant_id     = w_gv ? w_gid : '0;

    // Remember the last served requester for rotation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_ptr <= IW'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_last_ptr <= w_gid;
        end
    end

endmodule

// File: doc/sync_fifo_wr_arb.md
# sync_fifo_wr_arb

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Sits directly in front of the team's sync FIFO: accepts per-requester valid/data, grants one requester per cycle, and drives the FIFO's wr_en/wr_data while honouring its full flag. Optional burst locking keeps one producer's beats contiguous in the FIFO.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- DATA_WIDTH, 8, data width per requester and FIFO write data
- BURST_LEN, 4, max beats per lock (≥1, used only with FIFO_ARB_BURST_EN)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot or zero; beat of i transfers when req[i] & req_ready[i]
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_wr_data  out  DATA_WIDTH  FIFO write data
- grant_valid  out  1  a grant is issued this cycle
- grant_id  out  $clog2(NUM_REQ)  index of granted requester (0 when grant_valid=0)

## Operation
- State: last_ptr (index of last served requester), FSM {IDLE, LOCK}, owner, beat counter cnt ($clog2(BURST_LEN)+1 bits).
- Reset (rst=1 at edge): state IDLE, last_ptr=NUM_REQ-1 (requester 0 has top priority), owner=0, cnt=0.
- Outputs combinational from state and inputs; no output registers.
- IDLE: candidate = first i with req[i]=1 searching last_ptr+1, last_ptr+2, ... modulo NUM_REQ. grant_valid=|req, grant_id=candidate.
- LOCK: candidate = owner only, grant_valid=req[owner]; other requesters get req_ready=0 regardless of req.
- req_ready[grant_id] = grant_valid & ~fifo_full; all other bits 0.
- fifo_wr_en = grant_valid & ~fifo_full; fifo_wr_data = req_data slice of grant_id (0 when no grant).
- Beat accepted: last_ptr <= grant_id.
- fifo_full=1: no beat, no state change, last_ptr/cnt/owner hold; arbitration re-evaluated next cycle (in IDLE a higher-priority new request may win).
- fifo_wr_en is never 1 while fifo_full=1; FIFO overflow impossible through this block.
- Requesters must hold req and data stable until ready; the block does not check this.

## Timing
- Zero-cycle latency: beat presented with ready high is written in the same cycle's edge.
- Throughput: one beat per cycle while FIFO not full.
- IDLE→LOCK (burst build only, BURST_LEN>1): beat accepted in IDLE; owner<=grant_id, cnt<=1.
- LOCK, beat accepted: cnt<=cnt+1; if cnt+1==BURST_LEN → IDLE, cnt<=0.
- LOCK, req[owner]=0: no grant that cycle; → IDLE, cnt<=0 (one bubble cycle).
- LOCK, fifo_full=1 with req[owner]=1: stay LOCK, cnt holds.
- BURST_LEN=1: never enters LOCK.
- rst mid-burst: next cycle IDLE, last_ptr=NUM_REQ-1; outputs reflect IDLE arbitration immediately after.
- Wrap-around: search index NUM_REQ-1 followed by 0.

## Configuration
- FIFO_ARB_BURST_EN defined: IDLE/LOCK FSM as above; a granted requester keeps the port for up to BURST_LEN consecutive accepted beats.
- Not defined: FSM and cnt removed, block stays IDLE permanently; arbitration rotates after every accepted beat; BURST_LEN ignored.

## Test plan
- Reset: rst=1 two cycles with req=4'b1111 → after release, first grant_id=0, fifo_wr_en=1; during rst state cleared, no latch of stale owner.
- Round-robin, macro off: req=4'b1111 held, fifo_full=0 → grant_id sequence 0,1,2,3,0,1; fifo_wr_data matches each slice.
- Burst, macro on, BURST_LEN=4: req=4'b0101 held → grant_id 0,0,0,0,2,2,2,2,0; req_ready[2]=0 during requester 0 lock.
- Early release: macro on, requester 1 locked after 2 beats drops req, req[3]=1 → one cycle grant_valid=0, then grant_id=3.
- Full backpressure: fifo_full=1 for 3 cycles mid-burst at cnt=2 → fifo_wr_en=0, req_ready=0, cnt stays 2; after full drops, 2 more beats from owner then rotation.
- Sparse/wrap: last_ptr=3, req=4'b1000 only → grant_id=3 repeats each beat; then req=4'b1001 → next grant 0.
